// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing the regfile write port and rs read port among N_REQ
// requesters; each transaction runs IDLE -> ISSUE -> RESP and ends with a one-cycle ack.
module regfile_port_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned DW    = 8,
   parameter int unsigned AW    = 4,
   parameter int unsigned DEPTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req_i,
   input  logic [N_REQ-1:0]    we_i,
   input  logic [N_REQ*AW-1:0] addr_i,
   input  logic [N_REQ*DW-1:0] wdata_i,
   output logic [N_REQ-1:0]    ack_o,
   output logic [DW-1:0]       rdata_o,
   output logic                err_o,
   output logic [N_REQ-1:0]    gnt_o,
   output logic                rf_clk_en_o,
   output logic                rf_wrt_en_o,
   output logic [AW-1:0]       rf_rd_o,
   output logic [DW-1:0]       rf_dat_o,
   output logic [AW-1:0]       rf_rs_o,
   input  logic [DW-1:0]       rf_rs_dat_i
);

   localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   state_t            r_state;
   logic [PW-1:0]     r_rr_ptr;
   logic [PW-1:0]     r_win;
   logic              r_we;
   logic [AW-1:0]     r_addr;
   logic [N_REQ-1:0]  r_ack;
   logic [DW-1:0]     r_rdata;
   logic              r_err;
   logic [N_REQ-1:0]  r_gnt;
   logic              r_rf_clk_en;
   logic              r_rf_wrt_en;
   logic [AW-1:0]     r_rf_rd;
   logic [DW-1:0]     r_rf_dat;
   logic [AW-1:0]     r_rf_rs;

   logic [PW-1:0]     w_win;
   logic              w_we;
   logic [AW-1:0]     w_addr;
   logic [DW-1:0]     w_wdata;
   logic              w_new_oor;
   logic              w_cur_oor;

   // Winner: first requesting index at or above rr_ptr, wrapping around.
   always_comb begin
      logic          v_found;
      int unsigned   v_idx;
      logic [PW-1:0] v_sel;
      w_win   = r_rr_ptr;
      v_found = 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         v_idx = 32'(r_rr_ptr) + i;
         if (v_idx >= N_REQ) v_idx = v_idx - N_REQ;
         v_sel = PW'(v_idx);
         if (!v_found && req_i[v_sel]) begin
            v_found = 1'b1;
            w_win   = v_sel;
         end
      end
      w_we      = we_i[w_win];
      w_addr    = addr_i[32'(w_win)*AW +: AW];
      w_wdata   = wdata_i[32'(w_win)*DW +: DW];
      w_new_oor = (32'(w_addr) >= DEPTH);
      w_cur_oor = (32'(r_addr) >= DEPTH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_rr_ptr    <= '0;
         r_win       <= '0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_ack       <= '0;
         r_rdata     <= '0;
         r_err       <= 1'b0;
         r_gnt       <= '0;
         r_rf_clk_en <= 1'b0;
         r_rf_wrt_en <= 1'b0;
         r_rf_rd     <= '0;
         r_rf_dat    <= '0;
         r_rf_rs     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|req_i) begin
                  r_win       <= w_win;
                  r_we        <= w_we;
                  r_addr      <= w_addr;
                  r_gnt       <= N_REQ'(1) << w_win;
                  r_rf_clk_en <= 1'b1;
                  r_rf_rs     <= w_addr;
                  // Address 0 is hardwired and out-of-range addresses do not exist.
                  if (w_we && (w_addr != '0) && !w_new_oor) begin
                     r_rf_wrt_en <= 1'b1;
                     r_rf_rd     <= w_addr;
                     r_rf_dat    <= w_wdata;
                  end
                  r_state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_rf_clk_en <= 1'b0;
               r_rf_wrt_en <= 1'b0;
               r_rf_rd     <= '0;
               r_rf_dat    <= '0;
               r_rf_rs     <= '0;
               r_ack       <= N_REQ'(1) << r_win;
               r_err       <= w_cur_oor;
               // The regfile floats its read bus at address 0, so never pass it through.
               r_rdata     <= (!r_we && (r_addr != '0) && !w_cur_oor) ? rf_rs_dat_i : '0;
               r_state     <= ST_RESP;
            end
            ST_RESP: begin
               r_ack    <= '0;
               r_err    <= 1'b0;
               r_rdata  <= '0;
               r_gnt    <= '0;
               r_rr_ptr <= (r_win == PW'(N_REQ - 1)) ? '0 : r_win + PW'(1);
               r_state  <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ack_o       = r_ack;
   assign rdata_o     = r_rdata;
   assign err_o       = r_err;
   assign gnt_o       = r_gnt;
   assign rf_clk_en_o = r_rf_clk_en;
   assign rf_wrt_en_o = r_rf_wrt_en;
   assign rf_rd_o     = r_rf_rd;
   assign rf_dat_o    = r_rf_dat;
   assign rf_rs_o     = r_rf_rs;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: directed vector table, corner sequences, and random
// traffic against a transaction-level reference model with its own register image.
module tb_regfile_port_arbiter;

   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 8;
   localparam int PW    = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_i;
   logic [N-1:0]    we_i;
   logic [N*AW-1:0] addr_i;
   logic [N*DW-1:0] wdata_i;
   logic [N-1:0]    ack_o;
   logic [DW-1:0]   rdata_o;
   logic            err_o;
   logic [N-1:0]    gnt_o;
   logic            rf_clk_en_o;
   logic            rf_wrt_en_o;
   logic [AW-1:0]   rf_rd_o;
   logic [DW-1:0]   rf_dat_o;
   logic [AW-1:0]   rf_rs_o;
   logic [DW-1:0]   rf_rs_dat_i;

   int total = 0;
   int bad   = 0;
   logic chk_en;
   logic mem_clr;

   always #5 clk = ~clk;

   regfile_port_arbiter #(.N_REQ(N), .DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .ack_o(ack_o), .rdata_o(rdata_o), .err_o(err_o),
      .gnt_o(gnt_o), .rf_clk_en_o(rf_clk_en_o), .rf_wrt_en_o(rf_wrt_en_o),
      .rf_rd_o(rf_rd_o), .rf_dat_o(rf_dat_o), .rf_rs_o(rf_rs_o),
      .rf_rs_dat_i(rf_rs_dat_i)
   );

   // Register file stand-in; 8'hC3 models the floating bus at address 0 / beyond depth.
   logic [DW-1:0] rf_mem [DEPTH];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < DEPTH; i++) rf_mem[i] <= 8'(i * 37 + 11);
      end else if (rf_clk_en_o && rf_wrt_en_o && (rf_rd_o < 4'd8)) begin
         rf_mem[rf_rd_o[2:0]] <= rf_dat_o;
      end
   end
   assign rf_rs_dat_i = ((rf_rs_o == 4'd0) || (rf_rs_o >= 4'd8)) ? 8'hC3 : rf_mem[rf_rs_o[2:0]];

   task automatic check(input string name, input longint got, input longint exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
      end
   endtask

   // Reference model: each transaction occupies three cycles from its start edge.
   logic [DW-1:0] ref_mem [DEPTH];
   int            m_left, m_ptr, m_win, m_addr;
   logic          m_we;
   logic [DW-1:0] m_wdata;
   logic [N-1:0]  e_gnt, e_ack;
   logic          e_wrt, e_err, e_rd;
   logic [DW-1:0] e_rdata;

   always @(posedge clk or posedge rst) begin
      if (mem_clr)
         for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i * 37 + 11);
      if (rst) begin
         m_left = 0; m_ptr = 0; m_win = 0; m_addr = 0; m_we = 1'b0; m_wdata = '0;
         e_gnt = '0; e_ack = '0; e_wrt = 1'b0; e_err = 1'b0; e_rd = 1'b0; e_rdata = '0;
      end else begin
         e_ack = '0; e_wrt = 1'b0; e_err = 1'b0; e_rd = 1'b0; e_rdata = '0;
         if (m_left == 0) begin
            e_gnt = '0;
            if (req_i != '0) begin
               for (int i = 0; i < N; i++) begin
                  if (req_i[PW'((m_ptr + i) % N)]) begin
                     m_win = (m_ptr + i) % N;
                     break;
                  end
               end
               m_we    = we_i[PW'(m_win)];
               m_addr  = int'(addr_i[m_win*AW +: AW]);
               m_wdata = wdata_i[m_win*DW +: DW];
               e_gnt   = N'(1) << m_win;
               e_wrt   = m_we && (m_addr != 0) && (m_addr < DEPTH);
               m_left  = 2;
            end
         end else if (m_left == 2) begin
            if (m_we) begin
               if ((m_addr != 0) && (m_addr < DEPTH)) ref_mem[m_addr[2:0]] = m_wdata;
            end else begin
               e_rd    = 1'b1;
               e_rdata = ((m_addr != 0) && (m_addr < DEPTH)) ? ref_mem[m_addr[2:0]] : '0;
            end
            e_ack  = N'(1) << m_win;
            e_err  = (m_addr >= DEPTH);
            m_left = 1;
         end else begin
            m_ptr  = (m_win + 1) % N;
            e_gnt  = '0;
            m_left = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("rnd_gnt", longint'(gnt_o), longint'(e_gnt));
         check("rnd_ack", longint'(ack_o), longint'(e_ack));
         check("rnd_wrt_en", longint'(rf_wrt_en_o), longint'(e_wrt));
         if (e_ack != '0) check("rnd_err", longint'(err_o), longint'(e_err));
         if (e_rd) check("rnd_rdata", longint'(rdata_o), longint'(e_rdata));
      end
   end

   function automatic int idx_of(input logic [N-1:0] v);
      if ($countones(v) != 1) return -1;
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic longint all_outs();
      return longint'({ack_o, rdata_o, err_o, gnt_o, rf_clk_en_o, rf_wrt_en_o,
                       rf_rd_o, rf_dat_o, rf_rs_o});
   endfunction

   // Issue one request from an idle bus; returns ack latency and the cycle of any write.
   task automatic run_txn(input int k, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int lat, output int wat,
                          output logic [DW-1:0] rd, output logic er, output logic [N-1:0] av);
      lat = -1; wat = -1; rd = '0; er = 1'b0; av = '0;
      req_i[k] = 1'b1; we_i[k] = we; addr_i[k*AW +: AW] = a; wdata_i[k*DW +: DW] = d;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (rf_wrt_en_o && (wat < 0)) wat = c;
         if (ack_o != '0) begin
            lat = c; rd = rdata_o; er = err_o; av = ack_o;
            break;
         end
      end
      req_i[k] = 1'b0;
      @(negedge clk);
   endtask

   typedef struct {
      int            k;
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [DW-1:0] exp_rd;
      logic          exp_err;
      logic          exp_wrt;
      logic          chk_rd;
   } vec_t;

   vec_t tbl [10];
   int lat, wat, cnt, n;
   logic [DW-1:0] rd;
   logic er;
   logic [N-1:0] av;
   int order [8];

   initial begin
      tbl[0] = '{0, 1'b1, 4'd3,  8'hA5, 8'h00, 1'b0, 1'b1, 1'b0};
      tbl[1] = '{1, 1'b0, 4'd3,  8'h00, 8'hA5, 1'b0, 1'b0, 1'b1};
      tbl[2] = '{2, 1'b0, 4'd0,  8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{0, 1'b1, 4'd0,  8'hFF, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{3, 1'b0, 4'd0,  8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{1, 1'b0, 4'd9,  8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
      tbl[6] = '{2, 1'b1, 4'd12, 8'h33, 8'h00, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{3, 1'b1, 4'd7,  8'h5C, 8'h00, 1'b0, 1'b1, 1'b0};
      tbl[8] = '{0, 1'b0, 4'd7,  8'h00, 8'h5C, 1'b0, 1'b0, 1'b1};
      tbl[9] = '{1, 1'b0, 4'd3,  8'h00, 8'hA5, 1'b0, 1'b0, 1'b1};

      rst = 1'b1; mem_clr = 1'b1; chk_en = 1'b0;
      req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      mem_clr = 1'b0;
      check("reset_outs", all_outs(), 0);
      rst = 1'b0;

      // Quiet bus after reset
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (rf_wrt_en_o || rf_clk_en_o || (ack_o != '0) || (gnt_o != '0)) cnt++;
      end
      check("idle_quiet", cnt, 0);
      check("idle_outs", all_outs(), 0);

      // All four requesting continuously: strict rotation starting at 0
      req_i = '1; we_i = '0; addr_i = {4{4'd1}};
      n = 0;
      for (int c = 0; (c < 40) && (n < 8); c++) begin
         @(negedge clk);
         if (ack_o != '0) begin
            order[n] = idx_of(ack_o);
            n++;
         end
      end
      req_i = '0;
      check("rr_count", n, 8);
      for (int i = 0; i < n; i++) check($sformatf("rr_order%0d", i), order[i], i % N);
      repeat (3) @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         run_txn(tbl[i].k, tbl[i].we, tbl[i].a, tbl[i].d, lat, wat, rd, er, av);
         check($sformatf("v%0d_latency", i), lat, 2);
         check($sformatf("v%0d_ack", i), longint'(av), longint'(N'(1) << tbl[i].k));
         check($sformatf("v%0d_wrt_cycle", i), wat, tbl[i].exp_wrt ? 1 : -1);
         check($sformatf("v%0d_err", i), longint'(er), longint'(tbl[i].exp_err));
         if (tbl[i].chk_rd)
            check($sformatf("v%0d_rdata", i), longint'(rd), longint'(tbl[i].exp_rd));
      end

      // Reset during the ISSUE cycle of a write aborts it
      run_txn(0, 1'b1, 4'd5, 8'h11, lat, wat, rd, er, av);
      check("abort_setup_latency", lat, 2);
      req_i[2] = 1'b1; we_i[2] = 1'b1; addr_i[2*AW +: AW] = 4'd5; wdata_i[2*DW +: DW] = 8'h99;
      @(negedge clk);
      check("abort_in_issue", longint'(rf_wrt_en_o), 1);
      rst = 1'b1;
      req_i = '0;
      #1;
      check("abort_outs", all_outs(), 0);
      cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if ((ack_o != '0) || rf_wrt_en_o) cnt++;
      end
      check("abort_no_ack", cnt, 0);
      rst = 1'b0;
      @(negedge clk);
      run_txn(0, 1'b0, 4'd5, 8'h00, lat, wat, rd, er, av);
      check("abort_mem_kept", longint'(rd), 64'h11);

      // Random traffic against the reference model
      rst = 1'b1;
      @(negedge clk);
      mem_clr = 1'b1;
      @(negedge clk);
      mem_clr = 1'b0;
      rst = 1'b0;
      chk_en = 1'b1;
      repeat (1500) begin
         @(negedge clk);
         for (int k = 0; k < N; k++) begin
            if (ack_o[k]) req_i[k] = 1'b0;
            if (!req_i[k] && ($urandom_range(0, 3) == 0)) begin
               req_i[k] = 1'b1;
               we_i[k]  = 1'($urandom_range(0, 1));
               addr_i[k*AW +: AW]  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(8, 15))
                                                                 : AW'($urandom_range(0, 7));
               wdata_i[k*DW +: DW] = DW'($urandom);
            end else if (gnt_o[k] && ($urandom_range(0, 2) == 0)) begin
               we_i[k] = ~we_i[k];
               addr_i[k*AW +: AW]  = AW'($urandom_range(0, 15));
               wdata_i[k*DW +: DW] = DW'($urandom);
            end
         end
      end
      chk_en = 1'b0;
      req_i = '0;
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
